// File: rtl/fscmos_tx.sv
// Purpose: parallel CMOS sensor emulator producing vsync/href/data frames with a selectable test pattern.
// Latency: all outputs registered; vsync/busy rise on the edge that samples enable high in IDLE.
// Backpressure: none; once started, a frame always runs to completion (only cmos_reset aborts it).
module fscmos_tx #(
  parameter int C_OUT_WIDTH = 8,
  parameter int C_H_ACTIVE  = 640,
  parameter int C_H_BLANK   = 144,
  parameter int C_V_SYNC    = 3,
  parameter int C_V_BACK    = 17,
  parameter int C_V_ACTIVE  = 480,
  parameter int C_V_FRONT   = 10
) (
  input  logic                   cmos_pclk,
  input  logic                   cmos_reset,
  input  logic                   enable,
  input  logic [1:0]             pattern_sel,
  output logic                   cmos_vsync,
  output logic                   cmos_href,
  output logic [C_OUT_WIDTH-1:0] cmos_data,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int L     = C_H_ACTIVE + C_H_BLANK;
  localparam int HW    = $clog2(L);
  localparam int VMAX1 = (C_V_SYNC > C_V_BACK) ? C_V_SYNC : C_V_BACK;
  localparam int VMAX2 = (C_V_ACTIVE > C_V_FRONT) ? C_V_ACTIVE : C_V_FRONT;
  localparam int VMAX  = (VMAX1 > VMAX2) ? VMAX1 : VMAX2;
  localparam int VW    = $clog2(VMAX + 1);
  localparam int BAR_W = C_H_ACTIVE / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t                 state_q, state_d;
  logic [HW-1:0]          h_q, h_d;
  logic [VW-1:0]          v_q, v_d;
  logic [1:0]             mode_q, mode_d;
  logic [C_OUT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic                   vsync_q, vsync_d;
  logic                   href_q, href_d;
  logic [C_OUT_WIDTH-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic                   line_end;
  logic                   last_line;
  logic [HW-1:0]          bar;
  logic [C_OUT_WIDTH-1:0] pix;

  // Next-state logic: line/pixel counters and frame sequencing.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    line_end    = (h_q == HW'(L - 1));
    last_line   = 1'b0;

    case (state_q)
      S_VSYNC:  last_line = (v_q == VW'(C_V_SYNC - 1));
      S_VBACK:  last_line = (v_q == VW'(C_V_BACK - 1));
      S_ACTIVE: last_line = (v_q == VW'(C_V_ACTIVE - 1));
      S_VFRONT: last_line = (v_q == VW'(C_V_FRONT - 1));
      default:  last_line = 1'b0;
    endcase

    if (state_q == S_IDLE) begin
      h_d = '0;
      v_d = '0;
      if (enable) begin
        state_d = S_VSYNC;
        mode_d  = pattern_sel;
      end
    end else begin
      h_d = line_end ? '0 : h_q + 1'b1;
      if (line_end) begin
        if (last_line) begin
          // v_cnt restarts with every state change so it doubles as the active line index.
          v_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default: begin
              frame_cnt_d = frame_cnt_q + 1'b1;
              if (enable) begin
                state_d = S_VSYNC;
                mode_d  = pattern_sel;
              end else begin
                state_d = S_IDLE;
              end
            end
          endcase
        end else begin
          v_d = v_q + 1'b1;
        end
      end
    end
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    bar = h_d / HW'(BAR_W);
    case (mode_q)
      2'd0:    pix = C_OUT_WIDTH'(h_d);
      2'd1:    pix = C_OUT_WIDTH'(v_d);
      2'd2:    pix = C_OUT_WIDTH'(bar) << (C_OUT_WIDTH - 3);
      default: pix = C_OUT_WIDTH'(h_d) ^ frame_cnt_q;
    endcase
    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE) && (h_d < HW'(C_H_ACTIVE));
    data_d  = href_d ? pix : '0;
    done_d  = (state_d == S_VFRONT) && (h_d == HW'(L - 1)) && (v_d == VW'(C_V_FRONT - 1));
    busy_d  = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge cmos_pclk) begin
    if (cmos_reset) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign cmos_vsync = vsync_q;
  assign cmos_href  = href_q;
  assign cmos_data  = data_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fscmos_tx.sv
// Directed bench for fscmos_tx with a small frame (L=10, 60 cycles per frame).
// Cycle numbering: cycle 1 is the first cycle with vsync high after enable is sampled.
module tb_fscmos_tx;

  logic       cmos_pclk = 1'b0;
  logic       cmos_reset;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       cmos_vsync;
  logic       cmos_href;
  logic [7:0] cmos_data;
  logic       frame_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 cmos_pclk = ~cmos_pclk;

  fscmos_tx #(
    .C_OUT_WIDTH(8),
    .C_H_ACTIVE (8),
    .C_H_BLANK  (2),
    .C_V_SYNC   (1),
    .C_V_BACK   (1),
    .C_V_ACTIVE (3),
    .C_V_FRONT  (1)
  ) dut (
    .cmos_pclk  (cmos_pclk),
    .cmos_reset (cmos_reset),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .cmos_vsync (cmos_vsync),
    .cmos_href  (cmos_href),
    .cmos_data  (cmos_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected active pixel value for pixel x on the given active line index.
  function automatic logic [7:0] exp_pix(input int pat, input int x, input int line, input int fcnt);
    case (pat)
      0:       return 8'(x);
      1:       return 8'(line);
      2:       return 8'(x * 32);
      default: return 8'(x ^ fcnt);
    endcase
  endfunction

  // n cycles with every output at its reset/idle value.
  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cmos_pclk);
      check("idle_vsync", i, 32'(cmos_vsync), 32'd0);
      check("idle_href",  i, 32'(cmos_href),  32'd0);
      check("idle_data",  i, 32'(cmos_data),  32'd0);
      check("idle_done",  i, 32'(frame_done), 32'd0);
      check("idle_busy",  i, 32'(busy),       32'd0);
    end
  endtask

  // Checks cycles 1..ncyc of a frame. After checking cycle chg_at, pattern_sel
  // switches to new_pat; after cycle drop_at, enable is released.
  task automatic run_frame(input int pat, input int fcnt, input int ncyc,
                           input int chg_at, input logic [1:0] new_pat, input int drop_at);
    int         x;
    int         line;
    logic       act;
    logic       eh;
    logic [7:0] edat;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge cmos_pclk);
      act  = (c >= 21) && (c <= 50);
      x    = (c - 21) % 10;
      line = (c - 21) / 10;
      eh   = act && (x < 8);
      edat = eh ? exp_pix(pat, x, line, fcnt) : 8'd0;
      check("vsync", c, 32'(cmos_vsync), 32'(c <= 10));
      check("href",  c, 32'(cmos_href),  32'(eh));
      check("data",  c, 32'(cmos_data),  32'(edat));
      check("done",  c, 32'(frame_done), 32'(c == 60));
      check("busy",  c, 32'(busy),       32'd1);
      if (c == chg_at)  pattern_sel = new_pat;
      if (c == drop_at) enable = 1'b0;
    end
  endtask

  initial begin
    cmos_reset  = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge cmos_pclk);
    check_idle(1);

    // Back-to-back frames; pattern_sel changes mid-frame only affect the next frame.
    cmos_reset = 1'b0;
    enable     = 1'b1;
    run_frame(0, 0, 60, 30, 2'd1, 0);
    run_frame(1, 1, 60, 30, 2'd2, 0);
    run_frame(2, 2, 60, 30, 2'd3, 0);
    run_frame(3, 3, 60, 0,  2'd0, 0);
    // enable dropped at cycle 25: frame still completes, then idle.
    run_frame(3, 4, 60, 40, 2'd0, 25);
    check_idle(5);

    // Restart, then abort mid-ACTIVE with reset.
    enable = 1'b1;
    run_frame(0, 5, 33, 0, 2'd0, 0);
    cmos_reset  = 1'b1;
    pattern_sel = 2'd3;
    check_idle(1);
    cmos_reset = 1'b0;

    // Clean frames after the abort: frame_cnt restarted at 0.
    run_frame(3, 0, 60, 0, 2'd3, 0);
    run_frame(3, 1, 60, 0, 2'd3, 40);
    check_idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
